// File: rtl/stream_element.sv
// Token-ring record extractor: the token holder parses delimited records from
// the shared byte stream, hands the token on and presents each finished record.
module stream_element #(
  parameter int         DATA_BUS_WIDTH_BYTES     = 8,
  parameter logic [7:0] VARIABLEFIELD_DELIMITER  = 8'h2C,
  parameter int         MY_ID                    = 0,
  parameter int         RESET_TOKEN_HOLDER_ID    = 0,
  parameter int         FIXEDFIELD_LENGTH_BYTES  = 17,
  parameter int         MAX_VARIABLEFIELD_LENGTH = 16,
  parameter int         MAX_USE_BYTES            = 38
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [DATA_BUS_WIDTH_BYTES*8-1:0]       dataIn,
  input  logic                                    dataInValid,
  input  logic                                    tokenIn,
  input  logic [$clog2(DATA_BUS_WIDTH_BYTES)-1:0] firstByteOffsetIn,
  output logic                                    tokenOut,
  output logic [$clog2(DATA_BUS_WIDTH_BYTES)-1:0] firstByteOffsetOut,
  output logic [MAX_USE_BYTES*8-1:0]              USEStreamOut,
  output logic [$clog2(MAX_USE_BYTES+1)-1:0]      USEStreamByteLengthOut,
  output logic                                    USEStreamReadyOut,
  input  logic                                    USEStreamReadyAck
);
  // state   | meaning
  // S_IDLE  | no token, waiting for tokenIn
  // S_VAR   | appending variable-field bytes until delimiter or length cap
  // S_FIXED | appending the fixed field, r_fix_cnt counts down to the last byte
  // S_PASS  | record ended on the last lane; token leaves with the next valid beat

  localparam int  N      = DATA_BUS_WIDTH_BYTES;
  localparam int  OW     = $clog2(DATA_BUS_WIDTH_BYTES);
  localparam int  CW     = $clog2(MAX_USE_BYTES + 1);
  localparam int  VW     = $clog2(MAX_VARIABLEFIELD_LENGTH + 1);
  localparam int  FW     = $clog2(FIXEDFIELD_LENGTH_BYTES + 1);
  localparam bit  HOLDER = (MY_ID == RESET_TOKEN_HOLDER_ID);

  typedef enum logic [1:0] {S_IDLE, S_VAR, S_FIXED, S_PASS} state_t;

  state_t                     r_state, w_state;
  logic [N*8-1:0]             r_prev;
  logic [MAX_USE_BYTES*8-1:0] r_buf, w_buf;
  logic [CW-1:0]              r_cnt, w_cnt;
  logic [VW-1:0]              r_var_cnt, w_var_cnt;
  logic [FW-1:0]              r_fix_cnt, w_fix_cnt;
  logic                       w_take_tok;
  logic [2*N*8-1:0]           w_lanes;
  logic [2*N-1:0]             w_lane_en;
  logic [7:0]                 w_byte;
  logic                       w_done, w_done_last;
  logic [OW-1:0]              w_done_lane;
  logic                       w_tok;
  logic [OW-1:0]              w_tok_off;
  logic                       r_tok;
  logic [OW-1:0]              r_tok_off;
  logic [MAX_USE_BYTES*8-1:0] r_use;
  logic [CW-1:0]              r_len;
  logic                       r_ready;

  // Previous beat occupies the low lanes so one walk covers token-receipt order.
  assign w_lanes    = {dataIn, r_prev};
  assign w_take_tok = tokenIn && (r_state == S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= HOLDER ? S_VAR : S_IDLE;
    else        r_state <= w_state;
  end

  always_comb begin
    w_state     = r_state;
    w_buf       = r_buf;
    w_cnt       = r_cnt;
    w_var_cnt   = r_var_cnt;
    w_fix_cnt   = r_fix_cnt;
    w_done      = 1'b0;
    w_done_last = 1'b0;
    w_done_lane = '0;
    w_byte      = '0;
    w_lane_en   = '0;
    for (int j = 0; j < N; j++) begin
      w_lane_en[j]   = w_take_tok && (j >= int'(firstByteOffsetIn));
      w_lane_en[N+j] = dataInValid &&
                       (w_take_tok || r_state == S_VAR || r_state == S_FIXED);
    end
    if (w_take_tok) begin
      w_state   = S_VAR;
      w_buf     = '0;
      w_cnt     = '0;
      w_var_cnt = '0;
      w_fix_cnt = '0;
    end else if (r_state == S_PASS && dataInValid) begin
      w_state = S_IDLE;
    end
    for (int j = 0; j < 2*N; j++) begin
      w_byte = w_lanes[j*8 +: 8];
      if (w_lane_en[j] && (w_state == S_VAR || w_state == S_FIXED)) begin
        if (int'(w_cnt) < MAX_USE_BYTES) w_buf[int'(w_cnt)*8 +: 8] = w_byte;
        w_cnt = w_cnt + CW'(1);
        if (w_state == S_VAR) begin
          if (w_byte == VARIABLEFIELD_DELIMITER ||
              int'(w_var_cnt) == MAX_VARIABLEFIELD_LENGTH) begin
            w_state   = S_FIXED;
            w_fix_cnt = FW'(FIXEDFIELD_LENGTH_BYTES);
          end else begin
            w_var_cnt = w_var_cnt + VW'(1);
          end
        end else if (w_fix_cnt == FW'(1)) begin
          w_state     = S_IDLE;
          w_done      = 1'b1;
          w_done_lane = OW'(j % N);
          w_done_last = ((j % N) == N - 1);
        end else begin
          w_fix_cnt = w_fix_cnt - FW'(1);
        end
      end
    end
    if (w_done && w_done_last) w_state = S_PASS;
  end

  always_comb begin
    w_tok     = 1'b0;
    w_tok_off = '0;
    if (r_state == S_PASS && dataInValid) begin
      w_tok = 1'b1;
    end else if (w_done && !w_done_last) begin
      w_tok     = 1'b1;
      w_tok_off = w_done_lane + OW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev    <= '0;
      r_buf     <= '0;
      r_cnt     <= '0;
      r_var_cnt <= '0;
      r_fix_cnt <= '0;
      r_tok     <= 1'b0;
      r_tok_off <= '0;
      r_use     <= '0;
      r_len     <= '0;
      r_ready   <= 1'b0;
    end else begin
      if (dataInValid) r_prev <= dataIn;
      r_buf     <= w_buf;
      r_cnt     <= w_cnt;
      r_var_cnt <= w_var_cnt;
      r_fix_cnt <= w_fix_cnt;
      r_tok     <= w_tok;
      r_tok_off <= w_tok_off;
      // A new record overrides a pending ack and overwrites an unread one.
      if (w_done) begin
        r_use   <= w_buf;
        r_len   <= w_cnt;
        r_ready <= 1'b1;
      end else if (USEStreamReadyAck) begin
        r_ready <= 1'b0;
      end
    end
  end

  assign tokenOut               = r_tok;
  assign firstByteOffsetOut     = r_tok_off;
  assign USEStreamOut           = r_use;
  assign USEStreamByteLengthOut = r_len;
  assign USEStreamReadyOut      = r_ready;

endmodule

// File: tb/tb_stream_element.sv
// Ring of four stream_element instances fed one shared stream; a scoreboard
// queue holds each record as it is generated and is checked as records appear.
module tb_stream_element;
  localparam int N    = 8;
  localparam int MAXB = 38;
  typedef logic [MAXB*8-1:0] vec_t;
  typedef struct {
    int   inst;
    int   len;
    vec_t data;
  } exp_t;

  logic           clk        = 1'b0;
  logic           reset      = 1'b1;
  logic [N*8-1:0] data_in    = '0;
  logic           data_valid = 1'b0;
  logic           tok      [4];
  logic [2:0]     off      [4];
  vec_t           use_out  [4];
  logic [5:0]     use_len  [4];
  logic           rdy      [4];
  logic           ack      [4];
  logic           prev_rdy [4];
  exp_t           exp_q [$];
  logic [7:0]     byte_q [$];
  int             n_assert = 0;
  int             n_fail   = 0;
  int             lens [20] = '{27,21,21,24,31,19,26,23,33,33,31,19,19,20,29,19,30,19,20,21};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_ring
    stream_element #(.MY_ID(g), .RESET_TOKEN_HOLDER_ID(0)) u_dut (
      .clk                    (clk),
      .reset                  (reset),
      .dataIn                 (data_in),
      .dataInValid            (data_valid),
      .tokenIn                (tok[(g+3)%4]),
      .firstByteOffsetIn      (off[(g+3)%4]),
      .tokenOut               (tok[g]),
      .firstByteOffsetOut     (off[g]),
      .USEStreamOut           (use_out[g]),
      .USEStreamByteLengthOut (use_len[g]),
      .USEStreamReadyOut      (rdy[g]),
      .USEStreamReadyAck      (ack[g])
    );
  end

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Build one record into the byte stream and push its expected image.
  task automatic add_record(input int inst, input int nv, input bit cap, input logic [7:0] first);
    exp_t       e;
    logic [7:0] b;
    int         n = 0;
    e.data = '0;
    for (int k = 0; k < nv; k++) begin
      b = (k == 0) ? first : first + 8'(k*7 + 1);
      if (b == 8'h2C) b = 8'h2D;
      e.data[n*8 +: 8] = b; byte_q.push_back(b); n++;
    end
    b = cap ? 8'h41 : 8'h2C;
    e.data[n*8 +: 8] = b; byte_q.push_back(b); n++;
    for (int k = 0; k < 17; k++) begin
      b = (k % 5 == 1) ? 8'h2C : 8'(8'h80 + k);
      e.data[n*8 +: 8] = b; byte_q.push_back(b); n++;
    end
    e.inst = inst;
    e.len  = n;
    exp_q.push_back(e);
  endtask

  task automatic observe();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (rdy[i] && !prev_rdy[i]) begin
        n_assert++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_record: instance %0d produced length %0d with none outstanding", i, use_len[i]);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk($sformatf("rec_inst_%0d", i), vec_t'(i), vec_t'(e.inst));
          chk($sformatf("rec_len_%0d", i), vec_t'(use_len[i]), vec_t'(e.len));
          chk($sformatf("rec_data_%0d", i), use_out[i], e.data);
        end
      end
      prev_rdy[i] = rdy[i];
    end
  endtask

  task automatic step(input logic v, input logic [N*8-1:0] d);
    data_valid = v;
    data_in    = d;
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic run_stream(input int phase);
    logic [N*8-1:0] d;
    int             b = 0;
    while (byte_q.size() > 0) begin
      if (phase == 1 && (b == 6 || b == 10)) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, '0);
          if (b == 6) begin
            chk("pass_waits_in_gap", vec_t'(tok[1]), vec_t'(0));
            if (g == 0) chk("ready_cleared_by_ack", vec_t'(rdy[0]), vec_t'(0));
          end
        end
      end
      if (phase == 1 && b == 58) ack[0] = 1'b0;
      d = '0;
      for (int k = 0; k < N; k++)
        if (byte_q.size() > 0) d[k*8 +: 8] = byte_q.pop_front();
      step(1'b1, d);
      if (phase == 1 && b == 3) begin
        chk("midbeat_token", vec_t'(tok[0]), vec_t'(1));
        chk("midbeat_offset", vec_t'(off[0]), vec_t'(3));
        chk("first_ready", vec_t'(rdy[0]), vec_t'(1));
        chk("first_len", vec_t'(use_len[0]), vec_t'(27));
      end
      if (phase == 1 && (b == 4 || b == 5)) chk("ready_held", vec_t'(rdy[0]), vec_t'(1));
      if (phase == 1 && b == 5) begin
        chk("endbeat_no_token_yet", vec_t'(tok[1]), vec_t'(0));
        ack[0] = 1'b1;
      end
      if (phase == 1 && b == 6) begin
        chk("endbeat_token", vec_t'(tok[1]), vec_t'(1));
        chk("endbeat_offset", vec_t'(off[1]), vec_t'(0));
      end
      if (phase == 2 && b == 2) begin
        chk("post_reset_token", vec_t'(tok[0]), vec_t'(1));
        chk("post_reset_offset", vec_t'(off[0]), vec_t'(3));
      end
      b++;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      ack[i]      = 1'b1;
      prev_rdy[i] = 1'b0;
    end
    ack[0] = 1'b0;
    #2 reset = 1'b0;
    #10;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_ready_%0d", i), vec_t'(rdy[i]), vec_t'(0));
      chk($sformatf("reset_token_%0d", i), vec_t'(tok[i]), vec_t'(0));
      chk($sformatf("reset_offset_%0d", i), vec_t'(off[i]), vec_t'(0));
      chk($sformatf("reset_len_%0d", i), vec_t'(use_len[i]), vec_t'(0));
      chk($sformatf("reset_data_%0d", i), use_out[i], vec_t'(0));
    end
    reset = 1'b1;

    for (int r = 0; r < 20; r++) add_record(r % 4, lens[r] - 18, 1'b0, 8'(r));
    add_record(0, 16, 1'b1, 8'(20));
    run_stream(1);
    step(1'b0, '0);
    step(1'b0, '0);
    chk("cap_ready_held", vec_t'(rdy[0]), vec_t'(1));
    chk("cap_len", vec_t'(use_len[0]), vec_t'(34));

    #3 reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("midreset_ready_%0d", i), vec_t'(rdy[i]), vec_t'(0));
      chk($sformatf("midreset_token_%0d", i), vec_t'(tok[i]), vec_t'(0));
    end
    #2 reset = 1'b1;

    add_record(0, 1, 1'b0, 8'h55);
    run_stream(2);
    step(1'b0, '0);

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL records_outstanding: observed %0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
